multi_tick_divider: RTL and testbench

- Parametrised successor to the single fixed divider: NCH independent channels, each with a runtime-programmable divisor.
- Each channel generates a one-cycle tick enable and a 50%-duty square wave, both clocked by clk_in.
- Sits between the 12 MHz board clock and the display/counter logic, replacing per-consumer fixed dividers.
- Outputs are clock enables and a slow square wave for LEDs or debug; they are never used as clocks.

---
 rtl/multi_tick_divider.sv | 72 +++++++
 tb/tb_multi_tick_divider.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/multi_tick_divider.sv
// Multi-channel programmable clock-enable divider: each channel emits a one-cycle
// tick every act+1 cycles and a 50% square wave, with glitch-free divisor updates.
module multi_tick_divider #(
  parameter int NCH = 2,
  parameter int W = 20,
  parameter logic [W-1:0] DEF_DIV = {W{1'b1}},
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk_in,
  input  logic           rst,
  input  logic [NCH-1:0] en,
  input  logic           sync,
  input  logic           wr_en,
  input  logic [CW-1:0]  wr_ch,
  input  logic [W-1:0]   wr_div,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] sq
);

  // One spare bit so an out-of-range index can never alias onto a real channel.
  logic [CW:0] w_wrChExt;
  assign w_wrChExt = {1'b0, wr_ch};

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [W-1:0] r_cnt;
    logic [W-1:0] r_shadow;
    logic [W-1:0] r_act;
    logic         r_tick;
    logic         r_sq;
    logic         w_wrHit;

    assign w_wrHit = wr_en && (w_wrChExt == (CW+1)'(c));

    // act only ever copies the pre-write shadow, so a write landing on a wrap
    // edge takes effect one period later.
    always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
        r_cnt    <= '0;
        r_shadow <= DEF_DIV;
        r_act    <= DEF_DIV;
        r_tick   <= 1'b0;
        r_sq     <= 1'b0;
      end else begin
        if (w_wrHit) begin
          r_shadow <= wr_div;
        end
        if (sync) begin
          r_cnt  <= '0;
          r_tick <= 1'b0;
          r_sq   <= 1'b0;
          r_act  <= r_shadow;
        end else if (!en[c]) begin
          r_cnt  <= '0;
          r_tick <= 1'b0;
          r_act  <= r_shadow;
        end else if (r_cnt == r_act) begin
          r_cnt  <= '0;
          r_tick <= 1'b1;
          r_sq   <= ~r_sq;
          r_act  <= r_shadow;
        end else begin
          r_cnt  <= r_cnt + W'(1);
          r_tick <= 1'b0;
        end
      end
    end

    assign tick[c] = r_tick;
    assign sq[c]   = r_sq;
  end

endmodule

// File: tb/tb_multi_tick_divider.sv
// Randomised and directed bench for multi_tick_divider with a period-level
// reference model compared against tick/sq on every falling clock edge.
module tb_multi_tick_divider;
  localparam int NCH = 3;
  localparam int W = 4;
  localparam int CW = 2;
  localparam int DEFDIV = 15;

  logic           clk_in;
  logic           rst;
  logic [NCH-1:0] en;
  logic           sync;
  logic           wr_en;
  logic [CW-1:0]  wr_ch;
  logic [W-1:0]   wr_div;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] sq;

  int nChecks = 0;
  int nFails = 0;

  // Reference model: cycles elapsed in the current period, the divisor in force,
  // the divisor waiting to be adopted, and the visible outputs.
  int mElapsed[NCH];
  int mPeriodDiv[NCH];
  int mPendingDiv[NCH];
  bit mTick[NCH];
  bit mSq[NCH];

  multi_tick_divider #(.NCH(NCH), .W(W), .DEF_DIV(4'd15)) dut (
    .clk_in(clk_in),
    .rst(rst),
    .en(en),
    .sync(sync),
    .wr_en(wr_en),
    .wr_ch(wr_ch),
    .wr_div(wr_div),
    .tick(tick),
    .sq(sq)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
    end
  endtask

  task automatic resetModel();
    for (int c = 0; c < NCH; c++) begin
      mElapsed[c] = 0;
      mPeriodDiv[c] = DEFDIV;
      mPendingDiv[c] = DEFDIV;
      mTick[c] = 1'b0;
      mSq[c] = 1'b0;
    end
  endtask

  task automatic advanceModel();
    int adopt;
    for (int c = 0; c < NCH; c++) begin
      adopt = mPendingDiv[c];
      if (wr_en && int'(wr_ch) == c) mPendingDiv[c] = int'(wr_div);
      if (sync) begin
        mElapsed[c] = 0;
        mTick[c] = 1'b0;
        mSq[c] = 1'b0;
        mPeriodDiv[c] = adopt;
      end else if (!en[c]) begin
        mElapsed[c] = 0;
        mTick[c] = 1'b0;
        mPeriodDiv[c] = adopt;
      end else if (mElapsed[c] == mPeriodDiv[c]) begin
        mElapsed[c] = 0;
        mTick[c] = 1'b1;
        mSq[c] = !mSq[c];
        mPeriodDiv[c] = adopt;
      end else begin
        mElapsed[c] = mElapsed[c] + 1;
        mTick[c] = 1'b0;
      end
    end
  endtask

  initial begin
    resetModel();
    forever begin
      @(posedge clk_in or posedge rst);
      if (rst) resetModel();
      else advanceModel();
    end
  end

  // Every falling edge the DUT outputs must match the model.
  initial begin
    forever begin
      @(negedge clk_in);
      for (int c = 0; c < NCH; c++) begin
        checkOutput($sformatf("model_tick%0d", c), 8'(tick[c]), 8'(mTick[c]));
        checkOutput($sformatf("model_sq%0d", c), 8'(sq[c]), 8'(mSq[c]));
      end
    end
  end

  task automatic applyStimulus(input logic [NCH-1:0] enV, input logic syncV, input logic wrEnV,
                               input logic [CW-1:0] chV, input logic [W-1:0] divV);
    en = enV;
    sync = syncV;
    wr_en = wrEnV;
    wr_ch = chV;
    wr_div = divV;
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  initial begin
    rst = 1'b0; en = '0; sync = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_div = '0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk_in);
    checkOutput("reset_tick", 8'(tick), 8'd0);
    checkOutput("reset_sq", 8'(sq), 8'd0);

    // Default divide-by-16, then a mid-period write to channel 1 at cnt=7.
    rst = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      applyStimulus(3'b011, 1'b0, (i == 56), 2'd1, 4'd3);
      checkOutput("dflt_tick0", 8'(tick[0]), 8'(i % 16 == 0));
      checkOutput("dflt_sq0", 8'(sq[0]), 8'((i / 16) % 2 == 1));
      checkOutput("wr_tick1", 8'(tick[1]), 8'((i <= 64) ? (i % 16 == 0) : ((i - 64) % 4 == 0)));
    end

    // Divide-by-1 on channel 0 adopted through sync.
    applyStimulus(3'b011, 1'b0, 1'b1, 2'd0, 4'd0);
    applyStimulus(3'b011, 1'b1, 1'b0, 2'd0, 4'd0);
    checkOutput("sync_tick", 8'(tick), 8'd0);
    checkOutput("sync_sq", 8'(sq), 8'd0);
    for (int j = 1; j <= 8; j++) begin
      applyStimulus(3'b011, 1'b0, 1'b0, 2'd0, 4'd0);
      checkOutput("div1_tick0", 8'(tick[0]), 8'd1);
      checkOutput("div1_sq0", 8'(sq[0]), 8'(j % 2));
      checkOutput("sync_tick1", 8'(tick[1]), 8'(j % 4 == 0));
    end

    // Write on the exact wrap edge: old divisor for one more period.
    for (int j = 1; j <= 9; j++) begin
      applyStimulus(3'b011, 1'b0, (j == 1), 2'd0, 4'd2);
      checkOutput("wrapwr_tick0", 8'(tick[0]), 8'((j == 1) || ((j - 2) % 3 == 0)));
    end

    // Channel 1 paused for five cycles, then restarted.
    for (int j = 1; j <= 5; j++) begin
      applyStimulus(3'b001, 1'b0, 1'b0, 2'd0, 4'd0);
      checkOutput("pause_tick1", 8'(tick[1]), 8'd0);
    end
    for (int j = 1; j <= 8; j++) begin
      applyStimulus(3'b011, 1'b0, 1'b0, 2'd0, 4'd0);
      checkOutput("resume_tick1", 8'(tick[1]), 8'(j % 4 == 0));
    end

    // Randomised traffic, including out-of-range writes to index 3.
    begin
      logic [NCH-1:0] enR;
      enR = 3'b111;
      for (int n = 0; n < 600; n++) begin
        if ($urandom_range(0, 15) == 0) enR = NCH'($urandom_range(0, 7));
        applyStimulus(enR, ($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0),
                      CW'($urandom_range(0, 3)), W'($urandom_range(0, 15)));
      end
    end
    for (int j = 0; j < 20; j++) applyStimulus(3'b111, 1'b0, 1'b0, 2'd0, 4'd0);

    // Asynchronous reset mid-period with an out-of-range write pending.
    @(posedge clk_in);
    #2;
    rst = 1'b1; wr_en = 1'b1; wr_ch = 2'd3; wr_div = 4'd1;
    #1;
    checkOutput("async_rst_tick", 8'(tick), 8'd0);
    checkOutput("async_rst_sq", 8'(sq), 8'd0);
    @(negedge clk_in);
    applyStimulus(3'b000, 1'b0, 1'b1, 2'd3, 4'd1);
    applyStimulus(3'b000, 1'b0, 1'b1, 2'd3, 4'd1);
    rst = 1'b0;
    for (int i = 1; i <= 36; i++) begin
      applyStimulus(3'b111, 1'b0, (i == 1), 2'd3, 4'd1);
      checkOutput("post_rst_tick", 8'(tick), (i % 16 == 0) ? 8'h07 : 8'h00);
      checkOutput("post_rst_sq", 8'(sq), ((i / 16) % 2 == 1) ? 8'h07 : 8'h00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
